// File: rtl/hamming_decoder.sv
// Hamming(11,7) decoder with single-error correction, a two-stage
// valid/ready pipeline, and saturating counters for corrected and
// uncorrectable words.
// Parity bits sit at positions 1,2,4,8. Data bits 1..7 sit at positions
// 3,5,6,7,9,10,11. Parity is even.
module hamming_decoder #(
    parameter int DATA_WIDTH  = 7,
    parameter int CODE_WIDTH  = 11,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CODE_WIDTH:1]    in_code,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH:1]    out_data,
    output logic [4:1]             out_syndrome,
    output logic                   out_corrected,
    output logic                   out_uncorrectable,
    input  logic                   cnt_clear,
    output logic [COUNT_WIDTH-1:0] corrected_count,
    output logic [COUNT_WIDTH-1:0] uncorrectable_count
);

    logic                  adv;
    logic                  consume;
    logic [4:1]            syn_in;
    logic                  s1_valid;
    logic [CODE_WIDTH:1]   s1_code;
    logic [4:1]            s1_syn;
    logic [CODE_WIDTH:1]   fixed_code;
    logic [DATA_WIDTH:1]   fix_data;
    logic                  fix_corr;
    logic                  fix_unc;

    // Both stages move together, so a stall freezes the whole pipe.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign consume  = out_valid && out_ready;

    // Syndrome of the incoming word: XOR of the indices of all set bits.
    always_comb begin
        syn_in = '0;
        for (int n = 1; n <= CODE_WIDTH; n++) begin
            if (in_code[n]) begin
                syn_in = syn_in ^ 4'(n);
            end
        end
    end

    // Flip the bit the syndrome points at, then pull out the data positions.
    always_comb begin
        fixed_code = s1_code;
        for (int n = 1; n <= CODE_WIDTH; n++) begin
            if (s1_syn == 4'(n)) begin
                fixed_code[n] = ~s1_code[n];
            end
        end
        fix_data = {fixed_code[11], fixed_code[10], fixed_code[9],
                    fixed_code[7],  fixed_code[6],  fixed_code[5],
                    fixed_code[3]};
        fix_corr = (s1_syn != 4'd0) && (s1_syn <= 4'd11);
        fix_unc  = (s1_syn >= 4'd12);
    end

    // Stage 1: capture the received word and its syndrome.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
        end else if (adv) begin
            s1_valid <= in_valid && in_ready;
            s1_code  <= in_code;
            s1_syn   <= syn_in;
        end
    end

    // Stage 2: register the corrected data and the status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_syndrome      <= '0;
            out_corrected     <= 1'b0;
            out_uncorrectable <= 1'b0;
        end else if (adv) begin
            out_valid         <= s1_valid;
            out_data          <= fix_data;
            out_syndrome      <= s1_syn;
            out_corrected     <= fix_corr;
            out_uncorrectable <= fix_unc;
        end
    end

    // Saturating statistics counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || cnt_clear) begin
            corrected_count     <= '0;
            uncorrectable_count <= '0;
        end else begin
            if (consume && out_corrected && (corrected_count != '1)) begin
                corrected_count <= corrected_count + COUNT_WIDTH'(1);
            end
            if (consume && out_uncorrectable && (uncorrectable_count != '1)) begin
                uncorrectable_count <= uncorrectable_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_hamming_decoder.sv
// Bench for hamming_decoder: directed code vectors, backpressure,
// counter saturation and clear, reset mid-flight, and a random stream
// scored against a behavioural encode/decode model.
module tb_hamming_decoder;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [11:1]   in_code = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:1]    out_data;
    logic [4:1]    out_syndrome;
    logic          out_corrected;
    logic          out_uncorrectable;
    logic          cnt_clear = 1'b0;
    logic [CW-1:0] corrected_count;
    logic [CW-1:0] uncorrectable_count;

    hamming_decoder #(.DATA_WIDTH(7), .CODE_WIDTH(11), .COUNT_WIDTH(CW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_code             (in_code),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_syndrome        (out_syndrome),
        .out_corrected       (out_corrected),
        .out_uncorrectable   (out_uncorrectable),
        .cnt_clear           (cnt_clear),
        .corrected_count     (corrected_count),
        .uncorrectable_count (uncorrectable_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:1] data;
        logic [4:1] syn;
        logic       corr;
        logic       unc;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_emitted = 0;
    int         exp_corr = 0;
    int         exp_unc = 0;
    bit         stall_prev = 0;
    logic [7:1] h_data;
    logic [4:1] h_syn;
    logic       h_corr;
    logic       h_unc;

    // Reference decode: syndrome as XOR of set-bit indices, fix, extract.
    function automatic exp_t model(input logic [11:1] code);
        exp_t e;
        logic [11:1] c;
        int s;
        int k;
        c = code;
        s = 0;
        for (int n = 1; n <= 11; n++) if (c[n]) s = s ^ n;
        if (s >= 1 && s <= 11) c[s] = ~c[s];
        e.data = '0;
        k = 1;
        for (int n = 1; n <= 11; n++) begin
            if ((n & (n - 1)) != 0) begin
                e.data[k] = c[n];
                k++;
            end
        end
        e.syn  = 4'(s);
        e.corr = (s >= 1 && s <= 11);
        e.unc  = (s >= 12);
        return e;
    endfunction

    function automatic logic [11:1] encode(input logic [7:1] d);
        logic [11:1] c;
        int s;
        int k;
        c = '0;
        k = 1;
        for (int n = 1; n <= 11; n++) begin
            if ((n & (n - 1)) != 0) begin
                c[n] = d[k];
                k++;
            end
        end
        s = 0;
        for (int n = 1; n <= 11; n++) if (c[n]) s = s ^ n;
        c[1] = s[0];
        c[2] = s[1];
        c[4] = s[2];
        c[8] = s[3];
        return c;
    endfunction

    // One clock cycle: drive at the falling edge, score what the DUT shows,
    // then advance the model to match the coming rising edge.
    task automatic step(input logic iv, input logic [11:1] code,
                        input logic ordy, input logic clr);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        in_code   = code;
        out_ready = ordy;
        cnt_clear = clr;
        #1;
        n_checks++;
        if (corrected_count !== CW'(exp_corr) || uncorrectable_count !== CW'(exp_unc)) begin
            n_fail++;
            $display("FAIL counters: got corr=%0d unc=%0d, want corr=%0d unc=%0d",
                     corrected_count, uncorrectable_count, exp_corr, exp_unc);
        end
        n_checks++;
        if (in_ready !== (!out_valid || out_ready)) begin
            n_fail++;
            $display("FAIL in_ready: got %b with out_valid=%b out_ready=%b",
                     in_ready, out_valid, out_ready);
        end
        if (stall_prev) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== h_data || out_syndrome !== h_syn ||
                out_corrected !== h_corr || out_uncorrectable !== h_unc) begin
                n_fail++;
                $display("FAIL stall_hold: got v=%b d=%h s=%0d, want v=1 d=%h s=%0d",
                         out_valid, out_data, out_syndrome, h_data, h_syn);
            end
        end
        if (out_valid === 1'b1 && out_ready) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word: got d=%h s=%0d, want no word", out_data, out_syndrome);
            end else begin
                e = q.pop_front();
                n_emitted++;
                if (out_data !== e.data || out_syndrome !== e.syn ||
                    out_corrected !== e.corr || out_uncorrectable !== e.unc) begin
                    n_fail++;
                    $display("FAIL word: got d=%h s=%0d c=%b u=%b, want d=%h s=%0d c=%b u=%b",
                             out_data, out_syndrome, out_corrected, out_uncorrectable,
                             e.data, e.syn, e.corr, e.unc);
                end
                if (e.corr && exp_corr < CMAX) exp_corr++;
                if (e.unc && exp_unc < CMAX) exp_unc++;
            end
        end
        if (clr) begin
            exp_corr = 0;
            exp_unc  = 0;
        end
        if (iv && in_ready) q.push_back(model(code));
        stall_prev = (out_valid === 1'b1) && !out_ready;
        h_data = out_data;
        h_syn  = out_syndrome;
        h_corr = out_corrected;
        h_unc  = out_uncorrectable;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cnt_clear = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        exp_corr = 0;
        exp_unc = 0;
        stall_prev = 0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q.size() != 0 || out_valid === 1'b1) && k < 40) begin
            step(1'b0, '0, 1'b1, 1'b0);
            k++;
        end
        n_checks++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d words pending, want 0", q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_syndrome !== '0 ||
            out_corrected !== 1'b0 || out_uncorrectable !== 1'b0 ||
            corrected_count !== '0 || uncorrectable_count !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got v=%b d=%h s=%0d c=%b u=%b cc=%0d uc=%0d, want all 0",
                     out_valid, out_data, out_syndrome, out_corrected, out_uncorrectable,
                     corrected_count, uncorrectable_count);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
        q.delete();
        exp_corr = 0;
        exp_unc = 0;
        stall_prev = 0;
    endtask

    task automatic test_vectors();
        logic [11:1] codes[4] = '{11'h52F, 11'h50F, 11'h52E, 11'h5A7};
        logic [4:1]  syns[4]  = '{4'd0, 4'd6, 4'd1, 4'd12};
        logic        corrs[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic        uncs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        int          ccs[4]   = '{0, 1, 2, 2};
        int          ucs[4]   = '{0, 0, 0, 1};
        step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, codes[i], 1'b1, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL vec%0d_latency1: got out_valid=%b, want 0", i, out_valid);
            end
            step(1'b0, '0, 1'b1, 1'b0);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 7'h55 || out_syndrome !== syns[i] ||
                out_corrected !== corrs[i] || out_uncorrectable !== uncs[i]) begin
                n_fail++;
                $display("FAIL vec%0d_out: got v=%b d=%h s=%0d c=%b u=%b, want v=1 d=55 s=%0d c=%b u=%b",
                         i, out_valid, out_data, out_syndrome, out_corrected, out_uncorrectable,
                         syns[i], corrs[i], uncs[i]);
            end
            step(1'b0, '0, 1'b1, 1'b0);
            n_checks++;
            if (corrected_count !== CW'(ccs[i]) || uncorrectable_count !== CW'(ucs[i])) begin
                n_fail++;
                $display("FAIL vec%0d_count: got cc=%0d uc=%0d, want cc=%0d uc=%0d",
                         i, corrected_count, uncorrectable_count, ccs[i], ucs[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [11:1] w[4];
        int idx;
        int start;
        for (int i = 0; i < 4; i++) w[i] = encode(7'($urandom)) ^ (11'h1 << i);
        start = n_emitted;
        idx = 0;
        for (int c = 0; c < 16; c++) begin
            step(idx < 4, (idx < 4) ? w[idx] : 11'h0, !(c >= 2 && c <= 4), 1'b0);
            if (c >= 2 && c <= 4 && out_valid === 1'b1) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_in_ready: got %b, want 0", in_ready);
                end
            end
            if (idx < 4 && in_ready) idx++;
        end
        drain();
        n_checks++;
        if (n_emitted - start !== 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d words, want 4", n_emitted - start);
        end
    endtask

    task automatic test_counter_sat();
        step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, encode(7'(i)) ^ 11'h400, 1'b1, 1'b0);
        drain();
        n_checks++;
        if (corrected_count !== 4'hF) begin
            n_fail++;
            $display("FAIL cnt_saturate: got %0d, want 15", corrected_count);
        end
        step(1'b1, encode(7'h2A) ^ 11'h004, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (corrected_count !== '0) begin
            n_fail++;
            $display("FAIL cnt_clear_wins: got %0d, want 0", corrected_count);
        end
    endtask

    task automatic test_reset_midflight();
        step(1'b1, encode(7'h11), 1'b0, 1'b0);
        step(1'b1, encode(7'h22), 1'b0, 1'b0);
        step(1'b1, encode(7'h33), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_flush: got out_valid=%b, want 0", out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [11:1] c;
        int sent;
        int c1;
        int c2;
        sent = 0;
        for (int cyc = 0; cyc < 3000 && sent < 300; cyc++) begin
            c = encode(7'($urandom));
            case ($urandom_range(0, 2))
                0: ;
                1: c[$urandom_range(1, 11)] ^= 1'b1;
                default: begin
                    c1 = $urandom_range(1, 11);
                    c2 = $urandom_range(1, 10);
                    if (c2 >= c1) c2++;
                    c[c1] ^= 1'b1;
                    c[c2] ^= 1'b1;
                end
            endcase
            step(($urandom_range(0, 9) < 8), c, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 99) == 0));
            if (in_valid && in_ready) sent++;
        end
        drain();
        n_checks++;
        if (sent !== 300) begin
            n_fail++;
            $display("FAIL random_sent: got %0d, want 300", sent);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_counter_sat();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_decoder.md
HAMMING_DECODER -- requirements
Module: hamming_decoder

Interface
REQ-001 Parameter: DATA_WIDTH, 7, number of data bits; only 7 is supported.
REQ-002 Parameter: CODE_WIDTH, 11, number of codeword bits; only 11 is supported.
REQ-003 Parameter: COUNT_WIDTH, 16, width of each error statistics counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_code holds a codeword to decode.
REQ-007 in_ready  output  1  block accepts in_code this cycle.
REQ-008 in_code  input  [CODE_WIDTH:1]  received codeword, bit n = position n.
REQ-009 out_valid  output  1  out_* fields hold a decoded word.
REQ-010 out_ready  input  1  downstream accepts the decoded word this cycle.
REQ-011 out_data  output  [DATA_WIDTH:1]  decoded (corrected) data.
REQ-012 out_syndrome  output  [4:1]  syndrome of the word.
REQ-013 out_corrected  output  1  single-bit error located and corrected.
REQ-014 out_uncorrectable  output  1  syndrome points outside the codeword.
REQ-015 cnt_clear  input  1  synchronous clear of both counters.
REQ-016 corrected_count  output  [COUNT_WIDTH-1:0]  accepted words with out_corrected=1.
REQ-017 uncorrectable_count  output  [COUNT_WIDTH-1:0]  accepted words with out_uncorrectable=1.

Function
REQ-018 Code layout: parity at positions 1,2,4,8; data[1..7] at positions 3,5,6,7,9,10,11, in ascending order; even parity.
REQ-019 Syndrome = XOR of indices n (1..11) where in_code[n]=1; equivalently, bit k = parity over positions whose index has bit k set.
REQ-020 Syndrome 0: out_corrected=0, out_uncorrectable=0, data extracted unchanged.
REQ-021 Syndrome 1..11: codeword bit at that position inverted before extraction, out_corrected=1; a parity-position error still sets out_corrected=1 with data unchanged.
REQ-022 Syndrome 12..15: no correction, data extracted as received, out_uncorrectable=1, out_corrected=0.
REQ-023 Pipeline: stage 1 registers in_code and its syndrome; stage 2 registers corrected data and flags; latency 2 cycles from input acceptance to out_valid when not stalled.
REQ-024 Advance enable adv = !out_valid || out_ready; both stages load only when adv=1; in_ready = adv.
REQ-025 Input accepted iff in_valid && in_ready; output consumed iff out_valid && out_ready.
REQ-026 Stage-1 valid loads in_valid && in_ready on adv; stage-2 valid (out_valid) loads stage-1 valid on adv.
REQ-027 Full throughput: one word per cycle with out_ready held high; no bubbles inserted.
REQ-028 While stalled (adv=0), all out_* fields hold stable; no word dropped or duplicated.
REQ-029 in_code is ignored when in_valid=0; out_* data fields are don't-care when out_valid=0.
REQ-030 Counters increment by 1 only on output consumption with the corresponding flag set; saturate at all-ones, no wrap.
REQ-031 cnt_clear=1 forces both counters to 0 that cycle; clear wins over a simultaneous increment.

Reset
REQ-032 reset=1 on a clock edge: stage-1 valid=0, out_valid=0, out_data=0, out_syndrome=0, out_corrected=0, out_uncorrectable=0, both counters=0.
REQ-033 in_ready=1 in the first cycle after reset deasserts.
REQ-034 Reset mid-operation discards all in-flight words; nothing emitted for them afterward.

Verification
REQ-035 Clean word: in_code=11'h52F, out_ready=1 -> 2 cycles later out_data=7'h55, syndrome=0, corrected=0, uncorrectable=0.
REQ-036 Data error: in_code=11'h50F (bit 6 flipped) -> out_data=7'h55, syndrome=6, corrected=1; corrected_count=1 after acceptance.
REQ-037 Parity error: in_code=11'h52E (bit 1 flipped) -> out_data=7'h55, syndrome=1, corrected=1.
REQ-038 Uncorrectable: in_code=11'h5A7 (bits 4,8 flipped) -> syndrome=12, uncorrectable=1, corrected=0, out_data=7'h55; uncorrectable_count increments.
REQ-039 Backpressure: stream 4 words, out_ready low 3 cycles mid-stream -> in_ready=0 while out_valid=1, outputs stable, all 4 words emitted once, in order.
REQ-040 Counter edges: preload near saturation (COUNT_WIDTH=4, 16 corrected words) -> count holds 4'hF; cnt_clear with a simultaneous corrected acceptance -> count=0.
